// File: rtl/ltf_monitor.sv
// ltf_monitor: passive lamp-bus checker; latches the first fault (code + lowest semaphore) until fault_clr.
// Optional stuck-lamp watchdog compiled in with `define LTF_MON_STUCK_EN (MAX_HOLD unused otherwise).
module ltf_monitor #(
  parameter int N_SEM    = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SEM-1:0][0:2]      ltfs,
  input  logic                       attention,
  input  logic                       fault_clr,
  output logic                       fault,
  output logic [2:0]                 fault_code,
  output logic [$clog2(N_SEM)-1:0]   fault_sem,
  output logic [N_SEM-1:0]           active
);

  localparam int SEM_W = $clog2(N_SEM);
  localparam logic [2:0] P_OFF = 3'b000;
  localparam logic [2:0] P_RED = 3'b100;
  localparam logic [2:0] P_YEL = 3'b010;
  localparam logic [2:0] P_GRN = 3'b001;

  logic [N_SEM-1:0][2:0] prev_q, prev_d;
  logic [N_SEM-1:0]      active_q, active_d;
  logic                  fault_q, fault_d;
  logic [2:0]            fault_code_q, fault_code_d;
  logic [SEM_W-1:0]      fault_sem_q, fault_sem_d;

  logic [N_SEM-1:0] is_grn, v_ill, v_trn, v_sta, v_stk;
  logic             v_grn;
  logic             viol;
  logic [2:0]       new_code;
  logic [SEM_W-1:0] new_sem;

  function automatic logic [SEM_W-1:0] lowest(input logic [N_SEM-1:0] v);
    lowest = '0;
    for (int i = N_SEM - 1; i >= 0; i--) begin
      if (v[i]) lowest = SEM_W'(i);
    end
  endfunction

  always_comb begin
    logic [2:0] cur;
    logic [2:0] pv;
    logic       cur_ok;
    logic       step_ok;
    is_grn = '0;
    v_ill  = '0;
    v_trn  = '0;
    v_sta  = '0;
    for (int i = 0; i < N_SEM; i++) begin
      cur     = ltfs[i];
      pv      = prev_q[i];
      cur_ok  = (cur == P_OFF) || (cur == P_RED) || (cur == P_YEL) || (cur == P_GRN);
      step_ok = (cur == pv) ||
                (pv == P_OFF && cur == P_RED) || (pv == P_RED && cur == P_GRN) ||
                (pv == P_GRN && cur == P_YEL) || (pv == P_YEL && cur == P_RED);
      // Attention mode: anything legal may drop to yellow, and yellow may blink off.
      if (attention) begin
        step_ok = step_ok || (pv == P_YEL && cur == P_OFF) ||
                  (cur == P_YEL && ((pv == P_OFF) || (pv == P_RED) || (pv == P_YEL) || (pv == P_GRN)));
      end
      is_grn[i] = (cur == P_GRN);
      v_ill[i]  = !cur_ok;
      v_trn[i]  = cur_ok && !step_ok;
    end
    for (int i = 1; i < N_SEM; i++) begin
      v_sta[i] = (prev_q[i] == P_OFF) && (ltfs[i] != P_OFF) && !active_q[i-1];
    end
  end

  assign v_grn = ($countones(is_grn) > 1);

`ifdef LTF_MON_STUCK_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [N_SEM-1:0][CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    v_stk      = '0;
    for (int i = 0; i < N_SEM; i++) begin
      if (ltfs[i] == prev_q[i] && ltfs[i] != P_OFF && !attention) begin
        if (hold_cnt_q[i] < CNT_W'(MAX_HOLD)) hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
        v_stk[i] = (hold_cnt_q[i] == CNT_W'(MAX_HOLD - 1));
      end else begin
        hold_cnt_d[i] = (ltfs[i] != P_OFF) ? CNT_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt_q <= '0;
    else      hold_cnt_q <= hold_cnt_d;
  end
`else
  assign v_stk = '0;
`endif

  always_comb begin
    viol     = 1'b1;
    new_code = 3'd0;
    new_sem  = '0;
    if (v_grn) begin
      new_code = 3'd1; new_sem = lowest(is_grn);
    end else if (|v_ill) begin
      new_code = 3'd2; new_sem = lowest(v_ill);
    end else if (|v_trn) begin
      new_code = 3'd3; new_sem = lowest(v_trn);
    end else if (|v_sta) begin
      new_code = 3'd5; new_sem = lowest(v_sta);
    end else if (|v_stk) begin
      new_code = 3'd4; new_sem = lowest(v_stk);
    end else begin
      viol = 1'b0;
    end

    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    fault_sem_d  = fault_sem_q;
    // A fresh violation beats a clear landing on the same edge.
    if (viol && (!fault_q || fault_clr)) begin
      fault_d      = 1'b1;
      fault_code_d = new_code;
      fault_sem_d  = new_sem;
    end else if (fault_clr) begin
      fault_d      = 1'b0;
      fault_code_d = 3'd0;
      fault_sem_d  = '0;
    end

    for (int i = 0; i < N_SEM; i++) begin
      prev_d[i]   = ltfs[i];
      active_d[i] = active_q[i] | (ltfs[i] != P_OFF);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q       <= '0;
      active_q     <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
      fault_sem_q  <= '0;
    end else begin
      prev_q       <= prev_d;
      active_q     <= active_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fault_sem_q  <= fault_sem_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_sem  = fault_sem_q;
  assign active     = active_q;

endmodule
